// File: rtl/alu_decode_issue.sv
// Decode/issue stage for the 16-bit ALU: one registered issue slot fed over valid/ready,
// with HALT/illegal detection that stops intake until a flush.
module alu_decode_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_op,
    output logic [2:0]       rs,
    output logic [2:0]       rt,
    output logic [2:0]       rd,
    output logic [15:0]      imm,
    output logic             use_imm,
    output logic             wr_en,
    output logic             halt,
    output logic             illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic        use_imm;
        logic        wr_en;
        logic        halt;
        logic        illegal;
    } dec_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    function automatic dec_t decode(input logic [15:0] ins);
        dec_t d;
        logic r_form;
        logic i1_form;
        logic i2_form;
        logic sext;
        d       = '0;
        r_form  = 1'b0;
        i1_form = 1'b0;
        i2_form = 1'b0;
        sext    = 1'b0;
        case (ins[15:11])
            5'b11011: begin r_form = 1'b1; d.op = {2'b00, ins[1:0]}; end
            5'b11010: begin r_form = 1'b1; d.op = {2'b01, ins[1:0]}; end
            5'b11100: begin r_form = 1'b1; d.op = 4'hC; end
            5'b11101: begin r_form = 1'b1; d.op = 4'hE; end
            5'b11110: begin r_form = 1'b1; d.op = 4'hF; end
            5'b11111: begin r_form = 1'b1; d.op = 4'hA; end
            5'b01000: begin i1_form = 1'b1; sext = 1'b1; d.op = 4'h0; end
            5'b01001: begin i1_form = 1'b1; sext = 1'b1; d.op = 4'h1; end
            5'b01010: begin i1_form = 1'b1; d.op = 4'h2; end
            5'b01011: begin i1_form = 1'b1; d.op = 4'h3; end
            // ROLI/SLLI/RORI/SRLI: the low opcode bits select the shift flavour directly
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                i1_form = 1'b1;
                d.op    = {2'b01, ins[12:11]};
            end
            5'b11001: begin i1_form = 1'b1; d.op = 4'h8; end
            5'b11000: begin i2_form = 1'b1; sext = 1'b1; d.op = 4'hB; end
            5'b10010: begin i2_form = 1'b1; d.op = 4'hD; end
            5'b00001: d.op = 4'h0;
            5'b00000: d.halt = 1'b1;
            default:  d.illegal = 1'b1;
        endcase

        if (r_form) begin
            d.rs = ins[10:8];
            d.rt = ins[7:5];
            d.rd = ins[4:2];
        end
        if (i1_form) begin
            d.rs  = ins[10:8];
            d.rd  = ins[7:5];
            d.imm = sext ? {{11{ins[4]}}, ins[4:0]} : {11'b0, ins[4:0]};
        end
        if (i2_form) begin
            d.rs  = ins[10:8];
            d.rd  = ins[10:8];
            d.imm = sext ? {{8{ins[7]}}, ins[7:0]} : {8'b0, ins[7:0]};
        end
        d.use_imm = i1_form | i2_form;
        d.wr_en   = r_form | i1_form | i2_form;
        return d;
    endfunction

    state_t           state;
    state_t           state_nxt;
    dec_t             dec_p0;
    dec_t             slot_p1;
    logic             vld_p1;
    logic             accept;
    logic             consume;
    logic [CNT_W-1:0] cnt;

    // ---- p0: combinational decode and handshake ----
    always_comb dec_p0 = decode(instr);

    assign consume  = vld_p1 & out_ready;
    assign in_ready = (state == ST_RUN) & (~vld_p1 | out_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_RUN;
        end else if (accept && (dec_p0.halt || dec_p0.illegal)) begin
            state_nxt = ST_HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- p1: issue slot register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            slot_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            slot_p1 <= dec_p0;
        end else if (consume) begin
            vld_p1 <= 1'b0;
        end
    end

    // Counts every slot execute takes, including one taken in the same cycle as a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (consume && !(&cnt)) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid  = vld_p1;
    assign alu_op     = slot_p1.op;
    assign rs         = slot_p1.rs;
    assign rt         = slot_p1.rt;
    assign rd         = slot_p1.rd;
    assign imm        = slot_p1.imm;
    assign use_imm    = slot_p1.use_imm;
    assign wr_en      = slot_p1.wr_en;
    assign halt       = slot_p1.halt;
    assign illegal    = slot_p1.illegal;
    assign issued_cnt = cnt;

endmodule

// File: tb/tb_alu_decode_issue.sv
// Bench for alu_decode_issue: opcode-table reference model checked every cycle,
// plus directed literal checks on the documented decode and handshake scenarios.
module tb_alu_decode_issue;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       alu_op;
    logic [2:0]       rs;
    logic [2:0]       rt;
    logic [2:0]       rd;
    logic [15:0]      imm;
    logic             use_imm;
    logic             wr_en;
    logic             halt;
    logic             illegal;
    logic [CNT_W-1:0] issued_cnt;

    alu_decode_issue #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .use_imm(use_imm),
        .wr_en(wr_en), .halt(halt), .illegal(illegal), .issued_cnt(issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [15:0] imm;
        logic        use_imm;
        logic        wr_en;
        logic        halt;
        logic        illegal;
    } exp_t;

    int   errs   = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;
    bit   m_vld    = 1'b0;
    bit   m_halted = 1'b0;
    int   m_cnt    = 0;
    exp_t m_slot   = '0;
    bit   m_acc;
    bit   m_cons;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode from the opcode table, using integer arithmetic for extension.
    function automatic exp_t model_dec(input logic [15:0] w);
        exp_t e;
        int   opc;
        int   v;
        e   = '0;
        opc = int'(w[15:11]);
        case (opc)
            26, 27, 28, 29, 30, 31: begin
                e.rs    = w[10:8];
                e.rt    = w[7:5];
                e.rd    = w[4:2];
                e.wr_en = 1'b1;
                v       = int'(w[1:0]);
                case (opc)
                    27:      e.op = 4'(v);
                    26:      e.op = 4'(4 + v);
                    28:      e.op = 4'd12;
                    29:      e.op = 4'd14;
                    30:      e.op = 4'd15;
                    default: e.op = 4'd10;
                endcase
            end
            8, 9, 10, 11, 20, 21, 22, 23, 25: begin
                e.rs      = w[10:8];
                e.rd      = w[7:5];
                e.wr_en   = 1'b1;
                e.use_imm = 1'b1;
                v         = int'(w[4:0]);
                if ((opc == 8 || opc == 9) && v >= 16) v = v - 32;
                e.imm = 16'(v);
                if (opc <= 11)      e.op = 4'(opc - 8);
                else if (opc == 25) e.op = 4'd8;
                else                e.op = 4'(opc - 16);
            end
            24, 18: begin
                e.rs      = w[10:8];
                e.rd      = w[10:8];
                e.wr_en   = 1'b1;
                e.use_imm = 1'b1;
                v         = int'(w[7:0]);
                if (opc == 24 && v >= 128) v = v - 256;
                e.imm = 16'(v);
                e.op  = (opc == 24) ? 4'd11 : 4'd13;
            end
            1:       e.op = 4'd0;
            0:       e.halt = 1'b1;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic bit m_ready();
        return !m_halted && (!m_vld || out_ready) && !flush;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld    = 1'b0;
            m_halted = 1'b0;
            m_cnt    = 0;
        end else begin
            m_acc  = in_valid && m_ready();
            m_cons = m_vld && out_ready;
            if (m_cons && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (flush) begin
                m_vld    = 1'b0;
                m_halted = 1'b0;
            end else if (m_acc) begin
                m_vld  = 1'b1;
                m_slot = model_dec(instr);
                if (m_slot.halt || m_slot.illegal) m_halted = 1'b1;
            end else if (m_cons) begin
                m_vld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_ready()));
            chk("out_valid", 32'(out_valid), 32'(m_vld));
            chk("issued_cnt", 32'(issued_cnt), m_cnt);
            if (m_vld) begin
                chk("alu_op", 32'(alu_op), 32'(m_slot.op));
                chk("rs", 32'(rs), 32'(m_slot.rs));
                chk("rt", 32'(rt), 32'(m_slot.rt));
                chk("rd", 32'(rd), 32'(m_slot.rd));
                chk("imm", 32'(imm), 32'(m_slot.imm));
                chk("use_imm", 32'(use_imm), 32'(m_slot.use_imm));
                chk("wr_en", 32'(wr_en), 32'(m_slot.wr_en));
                chk("halt", 32'(halt), 32'(m_slot.halt));
                chk("illegal", 32'(illegal), 32'(m_slot.illegal));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ins);
        in_valid = 1'b1;
        instr    = ins;
        step();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    logic [15:0] sweep [$] = '{16'hD9A1, 16'hD9A2, 16'hD9A3, 16'hD6F5, 16'hD0AE,
                               16'hE4E8, 16'hEC2C, 16'hF1FF, 16'hFA4B, 16'h4230,
                               16'h5555, 16'hA123, 16'hA9FF, 16'hB0AA, 16'hBDE1,
                               16'hC840, 16'hC07F, 16'h95FE, 16'h0FFF};

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_regs", 32'({rs, rt, rd}), 0);
        chk("rst_imm", 32'(imm), 0);
        chk("rst_flags", 32'({use_imm, wr_en, halt, illegal}), 0);
        chk("rst_cnt", 32'(issued_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;

        out_ready = 1'b1;
        send(16'hD9A0);
        chk("add_valid", 32'(out_valid), 1);
        chk("add_op", 32'(alu_op), 0);
        chk("add_rs", 32'(rs), 1);
        chk("add_rt", 32'(rt), 5);
        chk("add_rd", 32'(rd), 0);
        chk("add_use_imm", 32'(use_imm), 0);
        chk("add_wr_en", 32'(wr_en), 1);
        send(16'h495F);
        chk("subi_imm", 32'(imm), 'hFFFF);
        chk("subi_op", 32'(alu_op), 1);
        chk("subi_rd", 32'(rd), 2);
        send(16'h59FF);
        chk("andni_imm", 32'(imm), 'h001F);
        chk("andni_op", 32'(alu_op), 3);
        idle();
        chk("b2b_cnt", 32'(issued_cnt), 3);
        chk("b2b_drained", 32'(out_valid), 0);

        send(16'hC380);
        chk("lbi_imm", 32'(imm), 'hFF80);
        chk("lbi_op", 32'(alu_op), 'hB);
        chk("lbi_rs_rd", 32'({rs, rd}), 'o33);
        send(16'h9380);
        chk("slbi_imm", 32'(imm), 'h0080);
        chk("slbi_op", 32'(alu_op), 'hD);
        chk("slbi_rs_rd", 32'({rs, rd}), 'o33);
        idle();

        out_ready = 1'b0;
        send(16'hD9A0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_in_ready", 32'(in_ready), 0);
        end
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_op", 32'(alu_op), 0);
        chk("stall_regs", 32'({rs, rt, rd}), 'o150);
        chk("stall_cnt", 32'(issued_cnt), 5);
        out_ready = 1'b1;
        idle();
        chk("unstall_cnt", 32'(issued_cnt), 6);

        out_ready = 1'b0;
        send(16'h0000);
        chk("halt_flag", 32'(halt), 1);
        chk("halt_wr_en", 32'(wr_en), 0);
        instr = 16'hD9A0;
        step();
        step();
        chk("halt_in_ready", 32'(in_ready), 0);
        chk("halt_held", 32'(halt), 1);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 0);
        step();
        flush = 1'b0;
        #1;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_cnt", 32'(issued_cnt), 6);
        chk("flush_run", 32'(in_ready), 1);
        step();
        chk("post_flush_valid", 32'(out_valid), 1);
        chk("post_flush_halt", 32'(halt), 0);
        out_ready = 1'b1;
        idle();
        chk("post_flush_cnt", 32'(issued_cnt), 7);

        send(16'h3000);
        chk("illegal_flag", 32'(illegal), 1);
        chk("illegal_wr_en", 32'(wr_en), 0);
        instr = 16'hD9A0;
        #1;
        chk("illegal_in_ready", 32'(in_ready), 0);
        step();
        chk("illegal_drain_valid", 32'(out_valid), 0);
        chk("illegal_drain_cnt", 32'(issued_cnt), 8);
        step();
        chk("illegal_stays_halted", 32'(out_valid), 0);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;

        out_ready = 1'b0;
        send(16'h0800);
        chk("nop_wr_en", 32'(wr_en), 0);
        chk("nop_op", 32'(alu_op), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_consume_cnt", 32'(issued_cnt), 9);
        chk("flush_consume_valid", 32'(out_valid), 0);

        foreach (sweep[i]) send(sweep[i]);
        idle();
        for (int k = 0; k < 20; k++) send(16'h0800);
        idle();
        chk("cnt_saturated", 32'(issued_cnt), CNT_MAX);

        out_ready = 1'b0;
        send(16'hD9A0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_cnt", 32'(issued_cnt), 0);
        chk("arst_regs", 32'({alu_op, rs, rt, rd}), 0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(16'h495F);
        chk("after_arst_op", 32'(alu_op), 1);
        idle();
        chk("after_arst_cnt", 32'(issued_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
